// File: rtl/ysyx_22040759_csr_file_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, trap causes,
// exception-vector bit indices (matching the CSR-logic unit) and mstatus fields.
package ysyx_22040759_csr_file_pkg;

  localparam int XLEN     = 64;
  localparam int EXC_W    = 17;
  localparam int CSR_AW   = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MIP      = 12'h344;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MINSTRET = 12'hB02;
  localparam logic [CSR_AW-1:0] CSR_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL   = 64'd2;
  localparam logic [XLEN-1:0] CAUSE_BREAK     = 64'd3;
  localparam logic [XLEN-1:0] CAUSE_ECALL_M   = 64'd11;
  localparam logic [XLEN-1:0] CAUSE_TIMER_IRQ = 64'h8000_0000_0000_0007;

  localparam int EXC_ECALL   = 0;
  localparam int EXC_EBREAK  = 1;
  localparam int EXC_MRET    = 2;
  localparam int EXC_ILLEGAL = 3;
  localparam int EXC_CLINT   = 4;
  localparam int EXC_FENCEI  = 5;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIP_MTIP       = 7;

  localparam logic [XLEN-1:0] MSTATUS_RST = 64'h1800;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXC,
    EV_MRET,
    EV_IRQ
  } trap_event_e;

  // Synchronous exceptions resolve as illegal > ecall > ebreak.
  function automatic logic [XLEN-1:0] exc_cause(input logic [EXC_W-1:0] etype);
    if (etype[EXC_ILLEGAL])     return CAUSE_ILLEGAL;
    else if (etype[EXC_ECALL])  return CAUSE_ECALL_M;
    else                        return CAUSE_BREAK;
  endfunction

endpackage

// File: rtl/ysyx_22040759_csr_file_counter.sv
// 64-bit free-running counter with increment enable; a write overrides the
// increment in the same cycle so the written value appears unmodified.
module ysyx_22040759_csr_counter
  import ysyx_22040759_csr_file_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            i_inc,
  input  logic            i_wen,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_value
);

  logic [XLEN-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset)       r_count <= '0;
    else if (i_wen)  r_count <= i_wdata;
    else if (i_inc)  r_count <= r_count + 64'd1;
  end

  assign o_value = r_count;

endmodule

// File: rtl/ysyx_22040759_csr_file.sv
// Machine-mode CSR file and trap controller: serves CSR reads/writes, turns the
// exception vector and timer interrupt into one-cycle redirect pulses for IFU.
module ysyx_22040759_csr_file
  import ysyx_22040759_csr_file_pkg::*;
#(
  parameter logic [XLEN-1:0] HARTID    = 64'h0,
  parameter logic [XLEN-1:0] MTVEC_RST = 64'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CSR_AW-1:0] csr_raddr,
  output logic [XLEN-1:0]   csr_rdata,
  output logic              csr_rhit,
  input  logic              csr_wen,
  input  logic [CSR_AW-1:0] csr_waddr,
  input  logic [XLEN-1:0]   csr_wdata,
  input  logic [EXC_W-1:0]  exception_type,
  input  logic [XLEN-1:0]   exc_pc,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   next_pc,
  input  logic              timer_irq,
  output logic              trap_valid,
  output logic [XLEN-1:0]   trap_pc
);

  logic              r_mie;
  logic              r_mpie;
  logic              r_mtie;
  logic [XLEN-1:2]   r_mtvec;
  logic [XLEN-1:0]   r_mscratch;
  logic [XLEN-1:2]   r_mepc;
  logic [XLEN-1:0]   r_mcause;
  logic              r_trap_valid;
  logic [XLEN-1:0]   r_trap_pc;

  logic [XLEN-1:0]   w_mcycle;
  logic [XLEN-1:0]   w_minstret;
  logic              w_exc;
  logic              w_mret;
  logic              w_irq;
  logic              w_wen;
  trap_event_e       w_event;
  logic              w_unused;

  assign w_exc  = exception_type[EXC_ILLEGAL] | exception_type[EXC_ECALL]
                | exception_type[EXC_EBREAK];
  assign w_mret = exception_type[EXC_MRET];
  assign w_irq  = r_mie & r_mtie & timer_irq & commit_valid & ~w_exc & ~w_mret;
  // A trapping or returning instruction does not commit its CSR write.
  assign w_wen  = csr_wen & ~w_exc & ~w_mret & ~w_irq;

  assign w_unused = ^{exception_type[EXC_W-1:EXC_CLINT], exc_pc[1:0], next_pc[1:0]};

  always_comb begin
    w_event = EV_NONE;
    if (w_exc)       w_event = EV_EXC;
    else if (w_mret) w_event = EV_MRET;
    else if (w_irq)  w_event = EV_IRQ;
  end

  // NOTE: reset is synchronous and overrides every other update, including a
  // trap raised in the same cycle, so no redirect pulse follows a reset edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mie        <= MSTATUS_RST[MSTATUS_MIE];
      r_mpie       <= MSTATUS_RST[MSTATUS_MPIE];
      r_mtie       <= 1'b0;
      r_mtvec      <= MTVEC_RST[XLEN-1:2];
      r_mscratch   <= '0;
      r_mepc       <= '0;
      r_mcause     <= '0;
      r_trap_valid <= 1'b0;
      r_trap_pc    <= '0;
    end else begin
      if (w_wen) begin
        unique case (csr_waddr)
          CSR_MSTATUS: begin
            r_mie  <= csr_wdata[MSTATUS_MIE];
            r_mpie <= csr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:      r_mtie     <= csr_wdata[MIE_MTIE];
          CSR_MTVEC:    r_mtvec    <= csr_wdata[XLEN-1:2];
          CSR_MSCRATCH: r_mscratch <= csr_wdata;
          CSR_MEPC:     r_mepc     <= csr_wdata[XLEN-1:2];
          CSR_MCAUSE:   r_mcause   <= csr_wdata;
          default: ;
        endcase
      end

      unique case (w_event)
        EV_EXC: begin
          r_mepc    <= exc_pc[XLEN-1:2];
          r_mcause  <= exc_cause(exception_type);
          r_mpie    <= r_mie;
          r_mie     <= 1'b0;
          r_trap_pc <= {r_mtvec, 2'b00};
        end
        EV_IRQ: begin
          r_mepc    <= next_pc[XLEN-1:2];
          r_mcause  <= CAUSE_TIMER_IRQ;
          r_mpie    <= r_mie;
          r_mie     <= 1'b0;
          r_trap_pc <= {r_mtvec, 2'b00};
        end
        EV_MRET: begin
          r_mie     <= r_mpie;
          r_mpie    <= 1'b1;
          r_trap_pc <= {r_mepc, 2'b00};
        end
        default: ;
      endcase

      r_trap_valid <= (w_event != EV_NONE);
    end
  end

  ysyx_22040759_csr_counter u_mcycle (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (1'b1),
    .i_wen   (w_wen && (csr_waddr == CSR_MCYCLE)),
    .i_wdata (csr_wdata),
    .o_value (w_mcycle)
  );

  ysyx_22040759_csr_counter u_minstret (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (commit_valid & ~w_exc),
    .i_wen   (w_wen && (csr_waddr == CSR_MINSTRET)),
    .i_wdata (csr_wdata),
    .o_value (w_minstret)
  );

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case leaves a value held and no latch is inferred.
  always_comb begin
    csr_rdata = '0;
    csr_rhit  = 1'b1;
    unique case (csr_raddr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        csr_rdata[MSTATUS_MPIE]                  = r_mpie;
        csr_rdata[MSTATUS_MIE]                   = r_mie;
      end
      CSR_MIE:      csr_rdata[MIE_MTIE] = r_mtie;
      CSR_MTVEC:    csr_rdata = {r_mtvec, 2'b00};
      CSR_MSCRATCH: csr_rdata = r_mscratch;
      CSR_MEPC:     csr_rdata = {r_mepc, 2'b00};
      CSR_MCAUSE:   csr_rdata = r_mcause;
      CSR_MIP:      csr_rdata[MIP_MTIP] = timer_irq;
      CSR_MCYCLE:   csr_rdata = w_mcycle;
      CSR_MINSTRET: csr_rdata = w_minstret;
      CSR_MHARTID:  csr_rdata = HARTID;
      default:      csr_rhit  = 1'b0;
    endcase
  end

  assign trap_valid = r_trap_valid;
  assign trap_pc    = r_trap_pc;

endmodule
